// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: instruction opcode constants and the fetch FSM encoding.
package cpu_pkg;

    localparam logic [31:0] BUBBLE_INSTR = 32'hE000_0000;
    localparam logic [3:0]  END_OPCODE   = 4'b1111;
    localparam logic [3:0]  NOP_OPCODE   = 4'b1110;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_pc_next.sv
// Next-PC selection for the fetch stage; all arithmetic wraps modulo MEM_WORDS.
module pc_next
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int MEM_WORDS = 262144
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                stall,
    input  fetch_state_t        state,
    input  logic                end_hit,
    output logic [PC_WIDTH-1:0] pc_nxt
);

    // One extra bit so MEM_WORDS == 2**PC_WIDTH and pc+1 never overflow.
    localparam logic [PC_WIDTH:0] MW  = (PC_WIDTH+1)'(MEM_WORDS);
    localparam logic [PC_WIDTH:0] ONE = (PC_WIDTH+1)'(1);

    logic [PC_WIDTH:0] inc_w;
    logic [PC_WIDTH:0] tgt_w;

    assign inc_w = ({1'b0, pc} + ONE) % MW;
    assign tgt_w = {1'b0, redirect_pc} % MW;

    always_comb begin
        pc_nxt = pc;
        if (redirect) begin
            pc_nxt = tgt_w[PC_WIDTH-1:0];
        end else if (state == RUN && !stall && !end_hit) begin
            pc_nxt = inc_w[PC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, IF/ID pipeline register and RUN/DRAIN/HALT fetch FSM with stall and redirect.
// Handshake: stall_i high means decode refuses this cycle's IF/ID contents; redirect_i overrides it.
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int RESET_PC  = 0,
    parameter int MEM_WORDS = 262144
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr_i,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [31:0]         id_instr_o,
    output logic [PC_WIDTH-1:0] id_pc_o,
    output logic                id_valid_o,
    output logic                halted_o,
    output fetch_state_t        state_o
);

    fetch_state_t        state, state_nxt;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic [31:0]         id_instr_nxt;
    logic [PC_WIDTH-1:0] id_pc_nxt;
    logic                id_valid_nxt;
    logic                end_hit;

    assign end_hit = (instr_i[31:28] == END_OPCODE);
    assign state_o = state;

    pc_next #(
        .PC_WIDTH  (PC_WIDTH),
        .MEM_WORDS (MEM_WORDS)
    ) u_pc_next (
        .pc          (pc_o),
        .redirect    (redirect_i),
        .redirect_pc (redirect_pc_i),
        .stall       (stall_i),
        .state       (state),
        .end_hit     (end_hit),
        .pc_nxt      (pc_nxt)
    );

    always_comb begin
        state_nxt    = state;
        id_instr_nxt = id_instr_o;
        id_pc_nxt    = id_pc_o;
        id_valid_nxt = id_valid_o;
        if (redirect_i) begin
            // Squash whatever was fetched on the wrong path, including an end instruction.
            state_nxt    = RUN;
            id_instr_nxt = BUBBLE_INSTR;
            id_valid_nxt = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!stall_i) begin
                        id_instr_nxt = instr_i;
                        id_pc_nxt    = pc_o;
                        id_valid_nxt = 1'b1;
                        if (end_hit) state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (!stall_i) begin
                        id_instr_nxt = BUBBLE_INSTR;
                        id_valid_nxt = 1'b0;
                        state_nxt    = HALT;
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pc_o       <= PC_WIDTH'(RESET_PC);
            id_instr_o <= BUBBLE_INSTR;
            id_pc_o    <= '0;
            id_valid_o <= 1'b0;
            halted_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc_o       <= pc_nxt;
            id_instr_o <= id_instr_nxt;
            id_pc_o    <= id_pc_nxt;
            id_valid_o <= id_valid_nxt;
            halted_o   <= (state_nxt == HALT);
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed test-plan scenarios plus random stall/redirect traffic.
module tb_pc_fetch_ctrl;
    import cpu_pkg::*;

    localparam int PW    = 32;
    localparam int WORDS = 256;

    logic          clk;
    logic          rst_n;
    logic [31:0]   instr_i;
    logic          stall_i;
    logic          redirect_i;
    logic [PW-1:0] redirect_pc_i;
    logic [PW-1:0] pc_o;
    logic [31:0]   id_instr_o;
    logic [PW-1:0] id_pc_o;
    logic          id_valid_o;
    logic          halted_o;
    fetch_state_t  state_o;

    logic [31:0] mem [WORDS];

    int n_checks;
    int n_pass;

    // Reference model: fetch position, decode register, and how far past an end instruction we are.
    int unsigned m_pc;
    logic [31:0] m_instr;
    int unsigned m_idpc;
    logic        m_valid;
    int          m_after_end;

    pc_fetch_ctrl #(
        .PC_WIDTH  (PW),
        .RESET_PC  (0),
        .MEM_WORDS (WORDS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_i       (instr_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_o),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_valid_o    (id_valid_o),
        .halted_o      (halted_o),
        .state_o       (state_o)
    );

    assign instr_i = mem[pc_o[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc        = 0;
        m_instr     = 32'hE000_0000;
        m_idpc      = 0;
        m_valid     = 1'b0;
        m_after_end = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},     pc_o,                        m_pc);
        check({tag, ".instr"},  id_instr_o,                  m_instr);
        check({tag, ".id_pc"},  id_pc_o,                     m_idpc);
        check({tag, ".valid"},  {31'd0, id_valid_o},         {31'd0, m_valid});
        check({tag, ".halted"}, {31'd0, halted_o},           {31'd0, (m_after_end == 2)});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".pc"},     pc_o,                32'd0);
        check({tag, ".instr"},  id_instr_o,          32'hE000_0000);
        check({tag, ".id_pc"},  id_pc_o,             32'd0);
        check({tag, ".valid"},  {31'd0, id_valid_o}, 32'd0);
        check({tag, ".halted"}, {31'd0, halted_o},   32'd0);
    endtask

    // Called at a negedge: check outputs, apply inputs for the coming edge, advance model, move to next negedge.
    task automatic cycle(input logic stall, input logic redir, input int unsigned tgt, input string tag);
        logic [31:0] fetched;
        check_model(tag);
        stall_i       = stall;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        fetched = mem[m_pc];
        if (redir) begin
            m_pc        = tgt % WORDS;
            m_instr     = 32'hE000_0000;
            m_valid     = 1'b0;
            m_after_end = 0;
        end else if (m_after_end == 0 && !stall) begin
            m_instr = fetched;
            m_idpc  = m_pc;
            m_valid = 1'b1;
            if (fetched[31:28] == 4'hF) m_after_end = 1;
            else m_pc = (m_pc + 1) % WORDS;
        end else if (m_after_end == 1 && !stall) begin
            m_instr     = 32'hE000_0000;
            m_valid     = 1'b0;
            m_after_end = 2;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h0000_1000 + i;
        mem[0] = 32'h0000_0001;
        mem[1] = 32'h0000_0002;
        mem[2] = 32'h0000_0003;
        stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
        rst_n = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
        check_reset_values("reset");

        // Free run from reset.
        cycle(0, 0, 0, "run0");
        check("run.i1", id_instr_o, 32'h1); check("run.p0", id_pc_o, 32'd0);
        cycle(0, 0, 0, "run1");
        check("run.i2", id_instr_o, 32'h2); check("run.p1", id_pc_o, 32'd1);
        cycle(0, 0, 0, "run2");
        check("run.i3", id_instr_o, 32'h3); check("run.p2", id_pc_o, 32'd2);
        check("run.v", {31'd0, id_valid_o}, 32'd1);

        // Stall while pc_o is 5.
        cycle(0, 0, 0, "pre3");
        cycle(0, 0, 0, "pre4");
        check("stall.pc_at", pc_o, 32'd5);
        repeat (3) cycle(1, 0, 0, "stall");
        check("stall.pc", pc_o, 32'd5); check("stall.idpc", id_pc_o, 32'd4);
        cycle(0, 0, 0, "release");
        check("release.idpc", id_pc_o, 32'd5);

        // Redirect under stall while pc_o is 7.
        cycle(0, 0, 0, "pre6");
        check("redir.pc_at", pc_o, 32'd7);
        cycle(1, 1, 32'h40, "redir");
        check("redir.valid", {31'd0, id_valid_o}, 32'd0);
        check("redir.instr", id_instr_o, 32'hE000_0000);
        check("redir.pc", pc_o, 32'h40);
        cycle(0, 0, 0, "redir_after");
        check("redir.tgt_idpc", id_pc_o, 32'h40); check("redir.tgt_v", {31'd0, id_valid_o}, 32'd1);

        // End of program at word 3.
        mem[3] = 32'hF000_0000;
        cycle(0, 1, 3, "end_redir");
        cycle(0, 0, 0, "end_fetch");
        check("end.instr", id_instr_o, 32'hF000_0000); check("end.idpc", id_pc_o, 32'd3);
        check("end.pc", pc_o, 32'd3);
        check("end.halt_early", {31'd0, halted_o}, 32'd0);
        cycle(0, 0, 0, "end_drain");
        check("end.bubble", id_instr_o, 32'hE000_0000); check("end.halted", {31'd0, halted_o}, 32'd1);
        for (int i = 0; i < 6; i++) cycle(i[0], 0, 0, "halt_hold");
        check("halt.pc", pc_o, 32'd3);

        // Wrong-path end: redirect while draining.
        cycle(0, 1, 3, "wp_redir");
        cycle(0, 0, 0, "wp_fetch");
        cycle(0, 1, 32'h10, "wp_drain");
        check("wp.halted", {31'd0, halted_o}, 32'd0); check("wp.pc", pc_o, 32'h10);
        check("wp.state", {30'd0, state_o}, {30'd0, RUN});
        cycle(0, 0, 0, "wp_resume");
        check("wp.idpc", id_pc_o, 32'h10);

        // Redirect coinciding with end_hit discards the end instruction.
        cycle(0, 1, 3, "rx_redir");
        cycle(0, 1, 20, "rx_end");
        check("rx.valid", {31'd0, id_valid_o}, 32'd0); check("rx.pc", pc_o, 32'd20);
        cycle(0, 0, 0, "rx_after");
        check("rx.halted", {31'd0, halted_o}, 32'd0);

        // Wrap at MEM_WORDS-1 and out-of-range redirect targets.
        cycle(0, 1, 254, "wrap_redir");
        check("wrap.p254", pc_o, 32'd254);
        cycle(0, 0, 0, "wrap1");
        check("wrap.p255", pc_o, 32'd255);
        cycle(0, 0, 0, "wrap2");
        check("wrap.p0", pc_o, 32'd0);
        cycle(0, 1, 300, "mod_redir");
        check("mod.pc", pc_o, 32'd44);
        cycle(0, 1, 32'hFFFF_FFFF, "mod_redir2");
        check("mod.pc2", pc_o, 32'd255);

        // Random traffic against the model.
        for (int i = 0; i < WORDS; i++) begin
            r = $urandom;
            if ($urandom_range(0, 9) == 0) r[31:28] = 4'hF;
            else if (r[31:28] == 4'hF) r[31:28] = 4'h0;
            mem[i] = r;
        end
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 511), "rand");
        end

        // Asynchronous reset in the middle of HALT.
        mem[3] = 32'hF000_0000;
        cycle(0, 1, 3, "rh_redir");
        cycle(0, 0, 0, "rh_fetch");
        cycle(0, 0, 0, "rh_drain");
        check("rh.halted", {31'd0, halted_o}, 32'd1);
        #2;
        rst_n = 0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        stall_i = 0; redirect_i = 0;
        cycle(0, 0, 0, "post_reset");
        cycle(0, 0, 0, "post_reset2");
        check_model("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
